// File: rtl/csi_avg_sched.sv
// csi_avg_sched: round-robin scheduled moving-average engine time-shared by NUM_CH sample streams.
// Optional macro CSI_AVG_SCHED_CH_MASK_EN adds a per-channel grant enable input (ch_enable_in).
module csi_avg_sched #(
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  WINDOW_SHIFT = 4,
    parameter int unsigned  NUM_CH       = 4,
    localparam int unsigned CH_W         = $clog2(NUM_CH)
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_in,
    input  logic [NUM_CH-1:0]            req_valid_in,
    output logic [NUM_CH-1:0]            req_ready_out,
    input  logic                         clear_in,
`ifdef CSI_AVG_SCHED_CH_MASK_EN
    input  logic [NUM_CH-1:0]            ch_enable_in,
`endif
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [CH_W-1:0]              data_out_ch,
    output logic                         data_out_valid
);
    localparam int unsigned WINDOW_SIZE = 1 << WINDOW_SHIFT;
    localparam int unsigned SUM_W       = DATA_WIDTH + WINDOW_SHIFT;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;

    logic [DATA_WIDTH-1:0]   buf_q  [NUM_CH][WINDOW_SIZE];
    logic [WINDOW_SHIFT-1:0] addr_q [NUM_CH];
    logic                    full_q [NUM_CH];
    logic signed [SUM_W-1:0] sum_q  [NUM_CH];

    logic [DATA_WIDTH-1:0] data_q;
    logic [CH_W-1:0]       ch_q;
    logic                  valid_q;

    logic [NUM_CH-1:0]       eligible_c;
    logic                    hi_found_c, lo_found_c, grant_found_c;
    logic [CH_W-1:0]         hi_ch_c, lo_ch_c, grant_ch_c;
    logic                    accept_c, emit_c, wrap_c;
    logic [DATA_WIDTH-1:0]   sample_c, evict_c;
    logic [WINDOW_SHIFT-1:0] waddr_c;
    logic signed [SUM_W-1:0] new_sum_c;

`ifdef CSI_AVG_SCHED_CH_MASK_EN
    assign eligible_c = req_valid_in & ch_enable_in;
`else
    assign eligible_c = req_valid_in;
`endif

    // Round-robin: first eligible above last_grant, else first eligible at or below it.
    always_comb begin
        hi_found_c = 1'b0;
        lo_found_c = 1'b0;
        hi_ch_c    = '0;
        lo_ch_c    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!hi_found_c && eligible_c[c] && (CH_W'(c) > last_grant_q)) begin
                hi_found_c = 1'b1;
                hi_ch_c    = CH_W'(c);
            end
            if (!lo_found_c && eligible_c[c] && (CH_W'(c) <= last_grant_q)) begin
                lo_found_c = 1'b1;
                lo_ch_c    = CH_W'(c);
            end
        end
        grant_found_c = hi_found_c || lo_found_c;
        grant_ch_c    = hi_found_c ? hi_ch_c : lo_ch_c;
        accept_c      = rst_n_in && (state_q == ST_RUN) && !clear_in && grant_found_c;
        req_ready_out = accept_c ? (NUM_CH'(1) << grant_ch_c) : '0;
    end

    // Shared adder path operating on the granted channel's context.
    always_comb begin
        waddr_c   = addr_q[grant_ch_c];
        sample_c  = req_data_in[32'(grant_ch_c) * DATA_WIDTH +: DATA_WIDTH];
        evict_c   = full_q[grant_ch_c] ? buf_q[grant_ch_c][waddr_c] : '0;
        new_sum_c = sum_q[grant_ch_c]
                  + $signed({{WINDOW_SHIFT{sample_c[DATA_WIDTH-1]}}, sample_c})
                  - $signed({{WINDOW_SHIFT{evict_c[DATA_WIDTH-1]}}, evict_c});
        wrap_c    = (waddr_c == WINDOW_SHIFT'(WINDOW_SIZE - 1));
        emit_c    = accept_c && (full_q[grant_ch_c] || wrap_c);
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = accept_c ? grant_ch_c : last_grant_q;
        case (state_q)
            ST_RUN: begin
                if (clear_in) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CH_W'(NUM_CH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CH_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_RUN;
            clr_cnt_q    <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            data_q       <= '0;
            ch_q         <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            valid_q      <= emit_c;
            if (emit_c) begin
                data_q <= DATA_WIDTH'(new_sum_c >>> WINDOW_SHIFT);
                ch_q   <= grant_ch_c;
            end
        end
    end

    // Per-channel contexts; the clear sweep leaves sample buffers untouched.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                addr_q[c] <= '0;
                full_q[c] <= 1'b0;
                sum_q[c]  <= '0;
                for (int unsigned w = 0; w < WINDOW_SIZE; w++) begin
                    buf_q[c][w] <= '0;
                end
            end
        end else if (state_q == ST_CLEAR) begin
            addr_q[clr_cnt_q] <= '0;
            full_q[clr_cnt_q] <= 1'b0;
            sum_q[clr_cnt_q]  <= '0;
        end else if (accept_c) begin
            buf_q[grant_ch_c][waddr_c] <= sample_c;
            addr_q[grant_ch_c]         <= waddr_c + WINDOW_SHIFT'(1);
            sum_q[grant_ch_c]          <= new_sum_c;
            if (wrap_c) begin
                full_q[grant_ch_c] <= 1'b1;
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_ch    = ch_q;
    assign data_out_valid = valid_q;

endmodule

// File: tb/tb_csi_avg_sched.sv
// Bench for csi_avg_sched: window-model scoreboard plus per-scenario grant and output checks.
module tb_csi_avg_sched;
    localparam int unsigned DW    = 16;
    localparam int unsigned WS    = 2;
    localparam int unsigned NC    = 4;
    localparam int unsigned CW    = $clog2(NC);
    localparam int          WIN_I = 1 << WS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC*DW-1:0] req_data;
    logic [NC-1:0]    req_valid;
    logic [NC-1:0]    req_ready;
    logic             clear;
    logic [DW-1:0]    data_out;
    logic [CW-1:0]    data_out_ch;
    logic             data_out_valid;
`ifdef CSI_AVG_SCHED_CH_MASK_EN
    logic [NC-1:0]    ch_en;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int exp_ch[$];
    int exp_val[$];
    int win[NC][$];
    int clr_block = 0;
    int mon_ec, mon_ev, mod_x, mod_s, mod_q;

    csi_avg_sched #(.DATA_WIDTH(DW), .WINDOW_SHIFT(WS), .NUM_CH(NC)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_data_in   (req_data),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .clear_in      (clear),
`ifdef CSI_AVG_SCHED_CH_MASK_EN
        .ch_enable_in  (ch_en),
`endif
        .data_out      (data_out),
        .data_out_ch   (data_out_ch),
        .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: explicit per-channel sample window, mean by floor division.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) win[c].delete();
            exp_ch.delete();
            exp_val.delete();
            clr_block = 0;
        end else begin
            if (clr_block > 0) begin
                clr_block--;
            end else if (clear) begin
                for (int c = 0; c < NC; c++) win[c].delete();
                clr_block = NC;
            end
            for (int c = 0; c < NC; c++) begin
                if (req_valid[c] && req_ready[c]) begin
                    mod_x = int'($signed(req_data[c*DW +: DW]));
                    win[c].push_back(mod_x);
                    if (win[c].size() > WIN_I) void'(win[c].pop_front());
                    if (win[c].size() == WIN_I) begin
                        mod_s = 0;
                        foreach (win[c][i]) mod_s += win[c][i];
                        mod_q = mod_s / WIN_I;
                        if (mod_s < 0 && (mod_s % WIN_I) != 0) mod_q--;
                        exp_ch.push_back(c);
                        exp_val.push_back(mod_q);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && data_out_valid) begin
            n_total++;
            if (exp_val.size() == 0) begin
                $display("FAIL out_unexpected: got ch=%0d val=%0d, required no output",
                         data_out_ch, $signed(data_out));
            end else begin
                mon_ec = exp_ch.pop_front();
                mon_ev = exp_val.pop_front();
                if (int'(data_out_ch) !== mon_ec || int'($signed(data_out)) !== mon_ev)
                    $display("FAIL out_scoreboard: got ch=%0d val=%0d, required ch=%0d val=%0d",
                             data_out_ch, $signed(data_out), mon_ec, mon_ev);
                else
                    n_pass++;
            end
        end
    end

    task automatic set_ch(input int c, input int v);
        req_data[c*DW +: DW] = DW'(v);
    endtask

    task automatic chk_ready(input string name, input logic [NC-1:0] exp);
        n_total++;
        if (req_ready !== exp) $display("FAIL %s: ready got %b required %b", name, req_ready, exp);
        else n_pass++;
    endtask

    task automatic chk_out(input string name, input logic v, input int val, input int ch);
        n_total++;
        if (data_out_valid !== v || (v && (int'($signed(data_out)) !== val || int'(data_out_ch) !== ch)))
            $display("FAIL %s: got v=%b val=%0d ch=%0d required v=%b val=%0d ch=%0d",
                     name, data_out_valid, $signed(data_out), data_out_ch, v, val, ch);
        else n_pass++;
    endtask

    task automatic chk_drained(input string name);
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_val.size() != 0) $display("FAIL %s: %0d outputs missing, required 0", name, exp_val.size());
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; req_valid = '1; req_data = '0;
`ifdef CSI_AVG_SCHED_CH_MASK_EN
        ch_en = '1;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk_ready("reset_ready", '0);
        chk_out("reset_out_valid", 1'b0, 0, 0);
        n_total++;
        if (data_out !== '0 || data_out_ch !== '0)
            $display("FAIL reset_out_regs: got %0d/%0d required 0/0", data_out, data_out_ch);
        else n_pass++;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_channel();
        int s[5];
        s = '{4, 8, 12, 16, 20};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 3) chk_out("single_no_out", 1'b0, 0, 0);
            if (k == 4) chk_out("single_mean16", 1'b1, 10, 0);
            req_valid = 4'b0001;
            set_ch(0, s[k]);
            #1 chk_ready("single_grant", 4'b0001);
        end
        @(negedge clk);
        chk_out("single_mean20", 1'b1, 14, 0);
        req_valid = '0;
        chk_drained("single_drain");
    endtask

    task automatic test_negative_rounding();
        int s[4];
        s = '{-4, -4, -4, -5};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 4'b0010;
            set_ch(1, s[k]);
            #1 chk_ready("neg_grant", 4'b0010);
        end
        @(negedge clk);
        chk_out("neg_floor", 1'b1, -5, 1);
        req_valid = '0;
        chk_drained("neg_drain");
    endtask

    task automatic test_round_robin();
        int seq[3];
        seq = '{0, 1, 3};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < NC; c++) set_ch(c, int'($urandom_range(2000)) - 1000);
            req_valid = 4'b1111;
            #1 chk_ready("rr_all", NC'(1) << (k % 4));
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NC; c++) set_ch(c, int'($urandom_range(2000)) - 1000);
            req_valid = 4'b1011;
            #1 chk_ready("rr_skip2", NC'(1) << seq[k % 3]);
            @(negedge clk);
        end
        req_valid = '0;
        chk_drained("rr_drain");
    endtask

    task automatic test_interleave_clear();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 7) chk_out("inter_ch0", 1'b1, 100, 0);
            req_valid = 4'b1001;
            set_ch(0, 100);
            set_ch(3, -100);
            #1 chk_ready("inter_grant", (k % 2 == 0) ? 4'b0001 : 4'b1000);
        end
        @(negedge clk);
        chk_out("inter_ch3", 1'b1, -100, 3);
        clear = 1'b1;
        req_valid = 4'b0001;
        set_ch(0, 7);
        #1 chk_ready("clear_block", '0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            clear = (j == 2);
            #1 chk_ready("clear_sweep", '0);
        end
        @(negedge clk);
        clear = 1'b0;
        #1 chk_ready("clear_resume", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_out("clear_refill", 1'b0, 0, 0);
        end
        @(negedge clk);
        chk_out("clear_first_out", 1'b1, 7, 0);
        req_valid = '0;
        chk_drained("clear_drain");
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        req_valid = 4'b0001;
        set_ch(0, 9);
        #1 chk_ready("mid_grant", 4'b0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_valid_low", 1'b0, 0, 0);
        chk_ready("mid_ready_low", '0);
        n_total++;
        if (data_out !== '0) $display("FAIL mid_data_zero: got %0d required 0", data_out);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1011;
        #1 chk_ready("mid_first_grant", 4'b0001);
        repeat (3) @(negedge clk);
        req_valid = '0;
        chk_drained("mid_drain");
    endtask

`ifdef CSI_AVG_SCHED_CH_MASK_EN
    task automatic test_mask();
        do_reset();
        ch_en = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b1111;
            #1 chk_ready("mask_grant", (k % 2 == 0) ? 4'b0010 : 4'b1000);
            @(negedge clk);
        end
        req_valid = '0;
        ch_en = '1;
        chk_drained("mask_drain");
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_negative_rounding();
        test_round_robin();
        test_interleave_clear();
        test_reset_midstream();
`ifdef CSI_AVG_SCHED_CH_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
